// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the intersection control blocks.
//   - Lamp encodings driven onto every 3-bit vehicle/pedestrian lamp port.
//   - phase_e: phase state codes, also exported on the scheduler's phase port.
//   - dir_e: which green follows an all-red or walk interval.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b011;

  typedef enum logic [2:0] {
    S_NSG  = 3'd0,
    S_NSY  = 3'd1,
    S_AR_A = 3'd2,
    S_EWG  = 3'd3,
    S_EWY  = 3'd4,
    S_AR_B = 3'd5,
    S_WALK = 3'd6
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer
//   Dwell timer for one phase. Cleared on state entry, then counts up once
//   per cycle and saturates at all-ones (never wraps).
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     clr         clear request (count returns to 0 on the next edge)
//     thresh      compare threshold
//     count       current count
//     ge          count >= thresh
module tl_phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [TIMER_W-1:0] thresh,
  output logic [TIMER_W-1:0] count,
  output logic               ge
);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + TIMER_W'(1);
    end
  end

  assign count = cnt_q;
  assign ge    = (cnt_q >= thresh);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Demand-driven phase sequencer for a two-road intersection with a shared
//   pedestrian crossing. Green dwell is bounded by MIN_GREEN/MAX_GREEN under
//   contested demand; yellow, all-red and walk intervals are fixed.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     req_ns, req_ew   vehicle presence (level)
//     ped_req          pedestrian button (any-length pulse)
//     emerg, emerg_ew  emergency preemption request / direction (1=EW),
//                      present only when EMERG_PREEMPT_EN is defined
//     ns, ew           vehicle lamps (red 001, yellow 010, green 011)
//     p_ns, p_ew       pedestrian lamps
//     phase            current state code
//     ped_ack          one-cycle pulse in the first WALK cycle
//   Optional feature macro: EMERG_PREEMPT_EN.
//   Inputs are sampled directly; asynchronous sources need an upstream
//   synchronizer.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 4,
  parameter int TIMER_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_req,
`ifdef EMERG_PREEMPT_EN
  input  logic       emerg,
  input  logic       emerg_ew,
`endif
  output logic [2:0] ns,
  output logic [2:0] ew,
  output logic [2:0] p_ns,
  output logic [2:0] p_ew,
  output logic [2:0] phase,
  output logic       ped_ack
);

  localparam logic [TIMER_W-1:0] T_MIN    = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_MAX    = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW - 1);
  localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALL_RED - 1);
  localparam logic [TIMER_W-1:0] T_WALK   = TIMER_W'(WALK - 1);

  phase_e             state_q, state_d;
  dir_e               nxt_dir_q;
  logic               ped_pend_q;
  logic               walk_entry;
  logic               tmr_clr;
  logic               tmr_ge;
  logic [TIMER_W-1:0] tmr_thresh;
  logic [TIMER_W-1:0] tmr_cnt;
  logic               demand_ns;
  logic               demand_ew;
  logic               emg_ns;
  logic               emg_ew;

`ifdef EMERG_PREEMPT_EN
  assign emg_ns = emerg & ~emerg_ew;
  assign emg_ew = emerg &  emerg_ew;
`else
  assign emg_ns = 1'b0;
  assign emg_ew = 1'b0;
`endif

  // Demand seen by each green: the cross street or a waiting pedestrian.
  assign demand_ns = req_ew | ped_pend_q;
  assign demand_ew = req_ns | ped_pend_q;

  tl_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .thresh (tmr_thresh),
    .count  (tmr_cnt),
    .ge     (tmr_ge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_AR_B;
    end else begin
      state_q <= state_d;
    end
  end

  // A single threshold compare covers both green exits: with own request
  // released the MIN_GREEN bound applies, otherwise MAX_GREEN. Since
  // MAX_GREEN >= MIN_GREEN, this matches checking both bounds separately.
  always_comb begin
    state_d    = state_q;
    tmr_thresh = T_ALLRED;
    case (state_q)
      S_NSG: begin
        tmr_thresh = req_ns ? T_MAX : T_MIN;
        if (emg_ew) begin
          state_d = S_NSY;
        end else if (!emg_ns && demand_ns && tmr_ge) begin
          state_d = S_NSY;
        end
      end
      S_NSY: begin
        tmr_thresh = T_YELLOW;
        if (tmr_ge) state_d = S_AR_A;
      end
      S_AR_A: begin
        tmr_thresh = T_ALLRED;
        if (tmr_ge) begin
          if (emg_ns)          state_d = S_NSG;
          else if (emg_ew)     state_d = S_EWG;
          else if (ped_pend_q) state_d = S_WALK;
          else                 state_d = S_EWG;
        end
      end
      S_EWG: begin
        tmr_thresh = req_ew ? T_MAX : T_MIN;
        if (emg_ns) begin
          state_d = S_EWY;
        end else if (!emg_ew && demand_ew && tmr_ge) begin
          state_d = S_EWY;
        end
      end
      S_EWY: begin
        tmr_thresh = T_YELLOW;
        if (tmr_ge) state_d = S_AR_B;
      end
      S_AR_B: begin
        tmr_thresh = T_ALLRED;
        if (tmr_ge) begin
          if (emg_ew)          state_d = S_EWG;
          else if (emg_ns)     state_d = S_NSG;
          else if (ped_pend_q) state_d = S_WALK;
          else                 state_d = S_NSG;
        end
      end
      S_WALK: begin
        tmr_thresh = T_WALK;
        if (tmr_ge) state_d = (nxt_dir_q == DIR_EW) ? S_EWG : S_NSG;
      end
      default: begin
        state_d = S_AR_B;
      end
    endcase
  end

  assign tmr_clr    = (state_d != state_q);
  assign walk_entry = (state_d == S_WALK) && (state_q != S_WALK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_dir_q <= DIR_NS;
    end else if (state_q == S_AR_A) begin
      nxt_dir_q <= DIR_EW;
    end else if (state_q == S_AR_B) begin
      nxt_dir_q <= DIR_NS;
    end
  end

  // A press coinciding with WALK entry is served by that same walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend_q <= 1'b0;
    end else if (walk_entry) begin
      ped_pend_q <= 1'b0;
    end else if (ped_req) begin
      ped_pend_q <= 1'b1;
    end
  end

  always_comb begin
    ns   = LIGHT_RED;
    ew   = LIGHT_RED;
    p_ns = LIGHT_RED;
    p_ew = LIGHT_RED;
    case (state_q)
      S_NSG:   ns = LIGHT_GREEN;
      S_NSY:   ns = LIGHT_YELLOW;
      S_EWG:   ew = LIGHT_GREEN;
      S_EWY:   ew = LIGHT_YELLOW;
      S_WALK: begin
        p_ns = LIGHT_GREEN;
        p_ew = LIGHT_GREEN;
      end
      default: ;
    endcase
  end

  assign phase   = state_q;
  assign ped_ack = (state_q == S_WALK) && (tmr_cnt == '0);

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase sequencer for a two-road intersection with a shared pedestrian crossing. It replaces fixed-period light cycling. Vehicle-sensor and pedestrian-button requests drive the decision, with programmable minimum and maximum green, yellow, all-red and walk durations. It drives the same 3-bit lamp encoding used across the traffic-control designs: red=001, yellow=010, green=011.

## Interface
- MIN_GREEN, 4: minimum green dwell in cycles, at least 1
- MAX_GREEN, 12: maximum green dwell under contested demand, at least MIN_GREEN
- YELLOW, 2: yellow dwell in cycles, at least 1
- ALL_RED, 1: all-red clearance dwell in cycles, at least 1
- WALK, 4: pedestrian walk dwell in cycles, at least 1
- TIMER_W, 8: phase-timer width; must represent max(MAX_GREEN, WALK)-1
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_ns  in  1  NS vehicle present (level)
- req_ew  in  1  EW vehicle present (level)
- ped_req  in  1  pedestrian button (any-length pulse)
- ns, ew  out  3  vehicle lamps
- p_ns, p_ew  out  3  pedestrian lamps
- phase  out  3  current state code
- ped_ack  out  1  one-cycle pulse on WALK entry

## Operation
- States and codes: NSG=0, NSY=1, AR_A=2, EWG=3, EWY=4, AR_B=5, WALK=6. Codes 7 and any illegal code return to AR_B with all lamps red.
- Sequence: NSG→NSY→AR_A→(WALK if ped_pend)→EWG→EWY→AR_B→(WALK if ped_pend)→NSG.
- nxt_dir register: records the green that follows AR or WALK. AR_A sets it to EW; AR_B sets it to NS.
- timer: cleared on every state entry, then increments each cycle. It saturates at all-ones and never wraps.
- Fixed-dwell states: NSY and EWY last YELLOW cycles, AR_A and AR_B last ALL_RED cycles, WALK lasts WALK cycles.
- Green states (own/opposing from the direction's viewpoint):
  - demand = opposing req or ped_pend.
  - Leave when timer ≥ MIN_GREEN-1 and demand and own req is deasserted.
  - Otherwise leave when timer ≥ MAX_GREEN-1 and demand.
  - With no demand, rest in green indefinitely.
- ped_pend:
  - Set by ped_req in any state except the WALK-entry cycle.
  - Cleared on WALK entry; a ped_req in that same cycle is absorbed.
  - ped_req later during WALK sets it again.
- Lamps are a Moore decode of the registered state:
  - NSG: ns=011. NSY: ns=010.
  - EWG: ew=011. EWY: ew=010.
  - WALK: p_ns=p_ew=011.
  - Every lamp not named above is 001.

## Timing
- Reset values: state=AR_B, nxt_dir=NS, timer=0, ped_pend=0, ns=ew=p_ns=p_ew=001, phase=5, ped_ack=0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- After reset release, AR_B runs ALL_RED cycles, then NSG.
- Lamps and phase change in the same cycle as the state register, with zero added latency.
- ped_ack is high exactly in the first WALK cycle.
- Requests are sampled every rising edge. No input synchronizer is included; one is required upstream if inputs are asynchronous.

## Configuration
- EMERG_PREEMPT_EN defined:
  - Adds input emerg (1 bit, level) and input emerg_ew (1 bit; 1=EW, 0=NS).
  - While emerg=1 and the opposing green is active, go to yellow next cycle, ignoring MIN_GREEN.
  - After yellow, go through AR, skip WALK, then go to the requested green.
  - While emerg=1 in the requested green, hold that green. ped_pend is retained and served after emerg drops.
- EMERG_PREEMPT_EN undefined: the ports are absent and behaviour is exactly as above.

## Structure
- Shared package traffic_pkg holds:
  - Lamp constants LIGHT_RED=3'b001, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b011.
  - The phase state enum, for reuse by other intersection blocks.
- One sub-module, tl_phase_timer: clear input, increment, saturating TIMER_W counter, ≥-threshold compare output.
- Next-state logic, ped_pend and lamp decode stay in the top level.

## Test plan
- Reset, then release; no requests: all lamps 001 for 1 cycle, then ns=011 held for 100 cycles with phase=0.
- req_ew=1 from NSG entry, req_ns=0: 4 cycles NSG, 2 NSY, 1 AR_A, then ew=011 (phase=3).
- req_ns=req_ew=1 held: NSG lasts 12 cycles, then 2 yellow, 1 all-red, then EWG also lasts 12; alternation repeats.
- 1-cycle ped_req during NSG, no vehicle requests: NSY, AR_A, then WALK for 4 cycles with p_ns=p_ew=011 and ped_ack high in its first cycle only, then EWG.
- Assert rst_n=0 in the 2nd WALK cycle: all lamps 001 and phase=5 immediately, ped_pend=0; after release, NSG follows 1 cycle later with no WALK.
- With EMERG_PREEMPT_EN: NSG at timer=1, emerg=1 and emerg_ew=1 → NSY next cycle, then AR_A, then EWG; EWG holds while emerg=1 even with req_ns=1.
